bp_resolve_tables: RTL

- Consumer end of the branch-resolution interface. Takes the per-cycle resolved-branch record from the execute stage and trains a branch history table (BHT) and a branch target buffer (BTB).
- Also serves registered lookups to the fetch stage, so the frontend's next predictions reflect corrected outcomes.

---
 rtl/config_pkg.sv | 38 +++
 rtl/bp_btb.sv | 67 ++++++
 rtl/bp_resolve_tables.sv | 98 +++++++++
 3 files changed

// File: rtl/config_pkg.sv
// Shared types for the branch-resolution path between execute and the
// predictor tables (BHT direction counters, BTB indirect targets).
package config_pkg;

    localparam int VLEN            = 32;
    localparam int DEF_BHT_ENTRIES = 128;
    localparam int DEF_BTB_ENTRIES = 32;
    localparam int BTB_TAG_W       = 8;

    typedef enum logic [2:0] {
        NoCF,
        Branch,
        Jump,
        JumpR,
        Return
    } cf_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
        logic            is_mispredict;
        logic            is_taken;
        cf_t             cf_type;
    } bp_resolve_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] cnt;
    } bht_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [VLEN-1:0]      target;
    } btb_entry_t;

endpackage

// File: rtl/bp_btb.sv
// Branch target buffer: direct-mapped, tagged, one write port and one
// registered read port. Reads see table state from before the same-edge write.
module bp_btb
    import config_pkg::*;
#(
    parameter int ENTRIES  = DEF_BTB_ENTRIES,
    parameter int TAG_BITS = BTB_TAG_W
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            we_i,
    input  logic [VLEN-1:0] wpc_i,
    input  logic [VLEN-1:0] wtarget_i,
    input  logic            re_i,
    input  logic [VLEN-1:0] rpc_i,
    output logic            hit_o,
    output logic [VLEN-1:0] target_o
);

    localparam int IW = $clog2(ENTRIES);

    btb_entry_t            mem_q [ENTRIES];
    logic [IW-1:0]         widx;
    logic [IW-1:0]         ridx;
    logic [TAG_BITS-1:0]   wtag;
    logic [TAG_BITS-1:0]   rtag;
    btb_entry_t            rd;
    logic                  hit_d;
    logic                  hit_q;
    logic [VLEN-1:0]       target_q;

    assign widx = wpc_i[IW+1:2];
    assign ridx = rpc_i[IW+1:2];
    assign wtag = wpc_i[IW+2 +: TAG_BITS];
    assign rtag = rpc_i[IW+2 +: TAG_BITS];
    assign rd   = mem_q[ridx];

    assign hit_d = re_i && rd.valid && (rd.tag == rtag);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            hit_q    <= 1'b0;
            target_q <= '0;
        end else if (flush_i) begin
            // Contents may stay stale; a cleared valid bit masks them.
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i].valid <= 1'b0;
            end
            hit_q    <= 1'b0;
            target_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[widx] <= '{valid: 1'b1, tag: wtag, target: wtarget_i};
            end
            hit_q    <= hit_d;
            target_q <= hit_d ? rd.target : '0;
        end
    end

    assign hit_o    = hit_q;
    assign target_o = target_q;

endmodule

// File: rtl/bp_resolve_tables.sv
// Trains the BHT and BTB from resolved branches and serves 1-cycle
// registered lookups back to fetch.
module bp_resolve_tables
    import config_pkg::*;
#(
    parameter int BHT_ENTRIES  = DEF_BHT_ENTRIES,
    parameter int BTB_ENTRIES  = DEF_BTB_ENTRIES,
    parameter int BTB_TAG_BITS = BTB_TAG_W
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_bp_i,
    input  bp_resolve_t     resolved_branch_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] lookup_pc_i,
    output logic            bht_valid_o,
    output logic            bht_taken_o,
    output logic            btb_valid_o,
    output logic [VLEN-1:0] btb_target_o
);

    localparam int BI = $clog2(BHT_ENTRIES);

    bht_entry_t     bht_q [BHT_ENTRIES];
    logic [BI-1:0]  widx;
    logic [BI-1:0]  ridx;
    bht_entry_t     cur;
    bht_entry_t     bht_d;
    bht_entry_t     rd;
    logic           bht_we;
    logic           btb_we;
    logic           bht_valid_q;
    logic           bht_taken_q;

    assign widx   = resolved_branch_i.pc[BI+1:2];
    assign ridx   = lookup_pc_i[BI+1:2];
    assign cur    = bht_q[widx];
    assign rd     = bht_q[ridx];
    assign bht_we = resolved_branch_i.valid
                 && (resolved_branch_i.cf_type == Branch);
    assign btb_we = resolved_branch_i.valid
                 && (resolved_branch_i.cf_type == JumpR)
                 && resolved_branch_i.is_mispredict;

    always_comb begin
        bht_d = cur;
        if (!cur.valid) begin
            bht_d.valid = 1'b1;
            bht_d.cnt   = resolved_branch_i.is_taken ? 2'b10 : 2'b01;
        end else if (resolved_branch_i.is_taken) begin
            if (cur.cnt != 2'b11) bht_d.cnt = cur.cnt + 2'b01;
        end else begin
            if (cur.cnt != 2'b00) bht_d.cnt = cur.cnt - 2'b01;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= '0;
            end
            bht_valid_q <= 1'b0;
            bht_taken_q <= 1'b0;
        end else if (flush_bp_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i].valid <= 1'b0;
            end
            bht_valid_q <= 1'b0;
            bht_taken_q <= 1'b0;
        end else begin
            if (bht_we) begin
                bht_q[widx] <= bht_d;
            end
            bht_valid_q <= lookup_valid_i && rd.valid;
            bht_taken_q <= lookup_valid_i && rd.valid && rd.cnt[1];
        end
    end

    bp_btb #(
        .ENTRIES  (BTB_ENTRIES),
        .TAG_BITS (BTB_TAG_BITS)
    ) u_btb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (flush_bp_i),
        .we_i      (btb_we),
        .wpc_i     (resolved_branch_i.pc),
        .wtarget_i (resolved_branch_i.target_address),
        .re_i      (lookup_valid_i),
        .rpc_i     (lookup_pc_i),
        .hit_o     (btb_valid_o),
        .target_o  (btb_target_o)
    );

    assign bht_valid_o = bht_valid_q;
    assign bht_taken_o = bht_taken_q;

endmodule
